// File: rtl/motion_cmd_gen.sv
// Keyboard-to-velocity generator: decodes W/A/S/D from two HID keycodes and runs
// an accelerate/cruise/decelerate FSM per axis, emitting {Y, X} signed velocity bytes.

// One axis: 7-bit magnitude plus direction, ramped up every ACC_DIV frames.
// state  | meaning
// IDLE   | mag = 0, waiting for a request
// ACCEL  | ramping mag up by ACC_STEP every ACC_DIV frames
// CRUISE | holding mag = MAX_SPEED
// DECEL  | dropping mag by DEC_STEP per frame until it reaches 0
module motion_cmd_axis #(
    parameter int ACC_STEP  = 1,
    parameter int ACC_DIV   = 4,
    parameter int DEC_STEP  = 2,
    parameter int MAX_SPEED = 6
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       i_req_neg,
    input  logic       i_req_pos,
    output logic [7:0] o_byte_nxt
);
    localparam int DIV_W = (ACC_DIV > 1) ? $clog2(ACC_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ACC_DIV - 1);
    localparam logic [6:0] MAG_MAX = 7'(MAX_SPEED);
    localparam logic [6:0] MAG_ACC = 7'(ACC_STEP);
    localparam logic [6:0] MAG_DEC = 7'(DEC_STEP);

    typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_t;

    state_t           r_state, w_state_nxt;
    logic [6:0]       r_mag, w_mag_nxt;
    logic             r_dir, w_dir_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;

    logic             w_req_any;
    logic             w_same;
    logic [7:0]       w_sum;
    logic [6:0]       w_acc;
    logic [6:0]       w_dec;

    assign w_req_any = i_req_neg | i_req_pos;
    assign w_same    = w_req_any && (i_req_neg == r_dir);
    // Sum is formed in 8 bits so the clamp sees the true value, never a wrapped one.
    assign w_sum     = {1'b0, r_mag} + {1'b0, MAG_ACC};
    assign w_acc     = (w_sum >= {1'b0, MAG_MAX}) ? MAG_MAX : w_sum[6:0];
    assign w_dec     = (r_mag > MAG_DEC) ? (r_mag - MAG_DEC) : 7'd0;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_mag   <= 7'd0;
            r_dir   <= 1'b0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_dir   <= w_dir_nxt;
            r_div   <= w_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_dir_nxt   = r_dir;
        w_div_nxt   = r_div;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = S_ACCEL;
                    w_mag_nxt   = MAG_ACC;
                    w_dir_nxt   = i_req_neg;
                    w_div_nxt   = '0;
                end
            end
            S_ACCEL: begin
                if (w_same) begin
                    if (r_div == DIV_LAST) begin
                        w_mag_nxt = w_acc;
                        w_div_nxt = '0;
                        if (w_acc == MAG_MAX) w_state_nxt = S_CRUISE;
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end else begin
                    w_mag_nxt   = w_dec;
                    w_div_nxt   = '0;
                    w_state_nxt = (w_dec == 7'd0) ? S_IDLE : S_DECEL;
                end
            end
            S_CRUISE: begin
                if (w_same) begin
                    w_mag_nxt = MAG_MAX;
                end else begin
                    w_mag_nxt   = w_dec;
                    w_div_nxt   = '0;
                    w_state_nxt = (w_dec == 7'd0) ? S_IDLE : S_DECEL;
                end
            end
            default: begin
                // Opposite requests keep braking; direction only changes from IDLE.
                if (w_same) begin
                    w_state_nxt = S_ACCEL;
                    w_div_nxt   = '0;
                end else begin
                    w_mag_nxt   = w_dec;
                    w_state_nxt = (w_dec == 7'd0) ? S_IDLE : S_DECEL;
                end
            end
        endcase
    end

    always_comb begin
        o_byte_nxt = w_dir_nxt ? (8'd0 - {1'b0, w_mag_nxt}) : {1'b0, w_mag_nxt};
    end
endmodule

module motion_cmd_gen #(
    parameter int ACC_STEP  = 1,
    parameter int ACC_DIV   = 4,
    parameter int DEC_STEP  = 2,
    parameter int MAX_SPEED = 6
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode_a,
    input  logic [7:0]  keycode_b,
    output logic [15:0] motion,
    output logic        moving
);
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    logic        w_held_w, w_held_s, w_held_a, w_held_d;
    logic [7:0]  w_y_nxt, w_x_nxt;
    logic [15:0] r_motion;
    logic        r_moving;

    assign w_held_w = (keycode_a == KEY_W) || (keycode_b == KEY_W);
    assign w_held_s = (keycode_a == KEY_S) || (keycode_b == KEY_S);
    assign w_held_a = (keycode_a == KEY_A) || (keycode_b == KEY_A);
    assign w_held_d = (keycode_a == KEY_D) || (keycode_b == KEY_D);

    motion_cmd_axis #(
        .ACC_STEP(ACC_STEP), .ACC_DIV(ACC_DIV), .DEC_STEP(DEC_STEP), .MAX_SPEED(MAX_SPEED)
    ) u_axis_y (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .i_req_neg  (w_held_w & ~w_held_s),
        .i_req_pos  (w_held_s & ~w_held_w),
        .o_byte_nxt (w_y_nxt)
    );

    motion_cmd_axis #(
        .ACC_STEP(ACC_STEP), .ACC_DIV(ACC_DIV), .DEC_STEP(DEC_STEP), .MAX_SPEED(MAX_SPEED)
    ) u_axis_x (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .i_req_neg  (w_held_a & ~w_held_d),
        .i_req_pos  (w_held_d & ~w_held_a),
        .o_byte_nxt (w_x_nxt)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_motion <= 16'h0000;
            r_moving <= 1'b0;
        end else begin
            r_motion <= {w_y_nxt, w_x_nxt};
            r_moving <= |{w_y_nxt, w_x_nxt};
        end
    end

    assign motion = r_motion;
    assign moving = r_moving;
endmodule

// File: tb/tb_motion_cmd_gen.sv
// Directed bench for motion_cmd_gen: a table of {keys, edges, expected word} steps
// followed by hand-written sequences for DECEL re-press and asynchronous reset.
`timescale 1ns/1ps
module tb_motion_cmd_gen;
    logic        frame_clk;
    logic        Reset;
    logic [7:0]  keycode_a;
    logic [7:0]  keycode_b;
    logic [15:0] motion;
    logic        moving;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] KW = 8'h1A, KS = 8'h16, KA = 8'h04, KD = 8'h07;

    typedef struct {
        string       name;
        logic [7:0]  ka;
        logic [7:0]  kb;
        int          edges;
        logic [15:0] exp_motion;
        logic        exp_moving;
    } vec_t;

    vec_t vecs[$];

    motion_cmd_gen dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode_a (keycode_a),
        .keycode_b (keycode_b),
        .motion    (motion),
        .moving    (moving)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] em, input logic emv);
        n_checks++;
        if (motion !== em || moving !== emv) begin
            n_errors++;
            $display("FAIL %s: motion=%h moving=%b, expected motion=%h moving=%b",
                     name, motion, moving, em, emv);
        end
    endtask

    task automatic run(input logic [7:0] ka, input logic [7:0] kb, input int n);
        keycode_a = ka;
        keycode_b = kb;
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic add(input string nm, input logic [7:0] ka, input logic [7:0] kb,
                       input int n, input logic [15:0] em, input logic emv);
        vec_t v;
        v.name = nm; v.ka = ka; v.kb = kb; v.edges = n; v.exp_motion = em; v.exp_moving = emv;
        vecs.push_back(v);
    endtask

    initial begin
        add("d_edge1",      KD, 8'h00,  1, 16'h0001, 1'b1);
        add("d_edge4",      KD, 8'h00,  3, 16'h0001, 1'b1);
        add("d_edge5",      KD, 8'h00,  1, 16'h0002, 1'b1);
        add("d_edge20",     KD, 8'h00, 15, 16'h0005, 1'b1);
        add("d_edge21",     KD, 8'h00,  1, 16'h0006, 1'b1);
        add("d_saturate",   KD, 8'h00,  6, 16'h0006, 1'b1);
        add("rel_1",     8'h00, 8'h00,  1, 16'h0004, 1'b1);
        add("rel_2",     8'h00, 8'h00,  1, 16'h0002, 1'b1);
        add("rel_3",     8'h00, 8'h00,  1, 16'h0000, 1'b0);
        add("idle_stay", 8'h00, 8'h00,  2, 16'h0000, 1'b0);
        add("d_ramp2",      KD, 8'h00, 21, 16'h0006, 1'b1);
        add("rev_1",        KA, 8'h00,  1, 16'h0004, 1'b1);
        add("rev_2",        KA, 8'h00,  1, 16'h0002, 1'b1);
        add("rev_3",        KA, 8'h00,  1, 16'h0000, 1'b0);
        add("rev_ff",       KA, 8'h00,  1, 16'h00FF, 1'b1);
        add("rev_fb",       KA, 8'h00, 19, 16'h00FB, 1'b1);
        add("rev_fa",       KA, 8'h00,  1, 16'h00FA, 1'b1);
        add("rev_hold",     KA, 8'h00,  3, 16'h00FA, 1'b1);
        add("neg_rel_1", 8'h00, 8'h00,  1, 16'h00FC, 1'b1);
        add("neg_rel_2", 8'h00, 8'h00,  1, 16'h00FE, 1'b1);
        add("neg_rel_3", 8'h00, 8'h00,  1, 16'h0000, 1'b0);
        add("diag_wd",      KW,    KD,  1, 16'hFF01, 1'b1);
        add("diag_rel",  8'h00, 8'h00,  1, 16'h0000, 1'b0);
        add("ws_cancel",    KW,    KS,  1, 16'h0000, 1'b0);
        add("sw_cancel",    KS,    KW,  3, 16'h0000, 1'b0);
        add("dd_edge1",     KD,    KD,  1, 16'h0001, 1'b1);
        add("dd_edge5",     KD,    KD,  4, 16'h0002, 1'b1);
        add("dd_rel",    8'h00, 8'h00,  1, 16'h0000, 1'b0);
        add("unmapped",  8'h05, 8'h00,  2, 16'h0000, 1'b0);
        add("ad_cancel",    KA,    KD,  2, 16'h0000, 1'b0);
        add("acc_d",        KD, 8'h00,  5, 16'h0002, 1'b1);
        add("acc_opp_0",    KA, 8'h00,  1, 16'h0000, 1'b0);
        add("acc_opp_ff",   KA, 8'h00,  1, 16'h00FF, 1'b1);
        add("acc_opp_rel", 8'h00, 8'h00, 1, 16'h0000, 1'b0);
        add("s_edge1",      KS, 8'h00,  1, 16'h0100, 1'b1);
        add("s_edge21",     KS, 8'h00, 20, 16'h0600, 1'b1);
        add("s_rel",     8'h00, 8'h00,  3, 16'h0000, 1'b0);
        add("w_b_edge1", 8'h00,    KW,  1, 16'hFF00, 1'b1);
        add("w_rel",     8'h00, 8'h00,  1, 16'h0000, 1'b0);

        Reset = 1'b1;
        keycode_a = 8'h00;
        keycode_b = 8'h00;
        #1;
        check("reset_state", 16'h0000, 1'b0);
        #1;
        Reset = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].ka, vecs[i].kb, vecs[i].edges);
            check(vecs[i].name, vecs[i].exp_motion, vecs[i].exp_moving);
        end

        // DECEL re-press keeps the current magnitude and restarts the divider.
        run(KD, 8'h00, 21);    check("rp_cruise",  16'h0006, 1'b1);
        run(8'h00, 8'h00, 1);  check("rp_decel",   16'h0004, 1'b1);
        run(KD, 8'h00, 1);     check("rp_accel",   16'h0004, 1'b1);
        run(KD, 8'h00, 3);     check("rp_wait",    16'h0004, 1'b1);
        run(KD, 8'h00, 1);     check("rp_rise",    16'h0005, 1'b1);
        run(8'h00, 8'h00, 3);  check("rp_stop",    16'h0000, 1'b0);

        // Asynchronous reset between edges while diagonal motion is in progress.
        run(KD, 8'h00, 12);    check("ar_x3",      16'h0003, 1'b1);
        run(KD, KS, 9);        check("ar_0306",    16'h0306, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("ar_immediate", 16'h0000, 1'b0);
        keycode_b = 8'h00;
        #1;
        Reset = 1'b0;
        @(posedge frame_clk);
        #1;
        check("ar_first_edge", 16'h0001, 1'b1);
        run(KD, 8'h00, 3);     check("ar_div_hold", 16'h0001, 1'b1);
        run(KD, 8'h00, 1);     check("ar_div_step", 16'h0002, 1'b1);
        run(8'h00, 8'h00, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/motion_cmd_gen.md
# motion_cmd_gen

Per-frame keyboard-to-velocity generator that produces the 16-bit signed motion word consumed by the ball/player movement logic. It decodes up to two simultaneously held USB HID keycodes (W/A/S/D) and runs an independent accelerate/cruise/decelerate state machine per axis. It outputs `{Y velocity, X velocity}` as two two's-complement bytes; `8'h00` on an axis means "no motion".

## Interface

Parameters:
- `ACC_STEP`, default 1: magnitude added per acceleration step; legal range 1..127.
- `ACC_DIV`, default 4: frames between acceleration steps; legal range 1..255.
- `DEC_STEP`, default 2: magnitude removed per frame while decelerating; legal range 1..127.
- `MAX_SPEED`, default 6: saturation magnitude; legal range 1..127, and must be ≥ `ACC_STEP`.

Ports:
- `frame_clk`, input, 1: frame-rate clock; the only clock.
- `Reset`, input, 1: asynchronous, active-high reset.
- `keycode_a`, input, 8: first held HID keycode; `8'h00` means none.
- `keycode_b`, input, 8: second held HID keycode; `8'h00` means none.
- `motion`, output, 16: `[15:8]` is Y velocity and `[7:0]` is X velocity, each signed two's complement. Negative Y is up; negative X is left.
- `moving`, output, 1: high when `motion != 16'h0000`.

## Operation

- Key map:
  - `8'h1A` (W) requests Y negative.
  - `8'h16` (S) requests Y positive.
  - `8'h04` (A) requests X negative.
  - `8'h07` (D) requests X positive.
  - All other codes are ignored.
- A key present on either input counts as held. The same key on both inputs counts once.
- Per-axis request: if both opposing keys are held, or neither is held, the request is NONE. Otherwise the request is NEG or POS.
- Internal state per axis:
  - 7-bit magnitude `mag`
  - direction bit `dir`
  - divider counter `div_cnt` of width clog2(`ACC_DIV`), minimum 1
  - 2-bit state
- Output byte per axis: `dir ? -{1'b0,mag} : {1'b0,mag}`. The byte is never `8'h80`, and `mag=0` always outputs `8'h00`.
- Axis FSM (evaluated on each `frame_clk` rising edge):
  - **IDLE** (`mag=0`):
    - On request NEG/POS: go to ACCEL, set `mag<=ACC_STEP`, set `dir` from the request, set `div_cnt<=0`.
    - On NONE: stay in IDLE.
  - **ACCEL**, request in the same direction:
    - If `div_cnt==ACC_DIV-1`: set `mag<=min(mag+ACC_STEP, MAX_SPEED)` and `div_cnt<=0`. When the result equals `MAX_SPEED`, go to CRUISE.
    - Otherwise: `div_cnt<=div_cnt+1`.
  - **ACCEL**, request NONE or opposite: go to DECEL and apply the first decrement on this same edge.
  - **CRUISE**, request in the same direction: hold `mag=MAX_SPEED`.
  - **CRUISE**, otherwise: go to DECEL with the first decrement on this edge.
  - **DECEL**: each edge sets `mag<=(mag>DEC_STEP) ? mag-DEC_STEP : 0`.
    - When the result is 0: go to IDLE. `dir` is don't-care and the output is `8'h00`.
    - If the request returns to the same direction while `mag>0` after the decrement: go to ACCEL on the next edge, keeping `mag` and setting `div_cnt<=0`.
    - An opposite-direction request never flips `dir` directly. The axis must pass through IDLE (`mag=0`) for at least one edge first.
- Both axes are fully independent. Diagonal motion is the concurrent operation of both FSMs.
- Arithmetic: `mag+ACC_STEP` is computed in 8 bits before clamping, so no wrap is possible.

## Timing

- Reset (asynchronous, takes effect immediately):
  - both axes go to IDLE with `mag=0`, `dir=0`, `div_cnt=0`
  - `motion=16'h0000`, `moving=0`
- `motion` and `moving` are registered. A key first sampled at edge N appears on `motion` after edge N (1-frame latency). The downstream position register adds its own frame.
- Inputs are sampled only at `frame_clk` rising edges. Glitches between edges are invisible.
- Deassertion of `Reset` between edges: the first state update happens on the next rising edge.
- Reset asserted mid-acceleration or mid-deceleration: output goes to 0 with no ramp-down, and the divider clears.
- With the defaults, holding one key from IDLE gives `mag = k` after edge `4(k-1)+1`, i.e. `MAX_SPEED` is reached after edge 21.

## Test plan

- Reset, then hold `keycode_a=8'h07`: `motion[7:0]` reads 01 after edge 1, 02 after edge 5, 06 after edge 21, and holds at 06 after that. `motion[15:8]=00` throughout, and `moving=1` from edge 1.
- From X=+6, release all keys: X reads 04, 02, 00 on three successive edges. `moving` drops with the 00 value.
- From X=+6, hold `8'h04`: X reads 04, 02, 00, then FF, then FA once saturated (edge 21 after the FF edge).
- `keycode_a=8'h1A` and `keycode_b=8'h07` from IDLE: `motion=16'hFF01` after edge 1. `keycode_a=8'h1A` with `keycode_b=8'h16`: Y stays 00. `keycode_a=keycode_b=8'h07`: behaves as a single D press.
- At X=+4 during DECEL, re-press D: the next edge continues ACCEL from the current value, and the value rises only after 4 further edges.
- Assert `Reset` between edges while `motion=16'h0306`: `motion` is 0000 immediately, not waiting for an edge. With D still held after release of Reset, the first edge gives X=01.
